// File: rtl/ddr_wr_burst_engine.sv
// DDR write-data path: queues write bursts and serialises one onto DQ/DQS per wr_rdy strobe.
// Optional data-bus inversion on the DQ lanes is enabled by defining WR_DBI_EN (adds dbi_n).
module ddr_wr_burst_engine #(
  parameter int DQ_W       = 8,
  parameter int MAX_BL     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int DATA_W    = MAX_BL * DQ_W
) (
  input  logic              CK_t,
  input  logic              reset,
  input  logic              wr_push,
  input  logic              bl_mode,
  input  logic              wr_pre,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_rdy,
  output logic [DQ_W-1:0]   dq,
  output logic              dq_oe,
  output logic              dqs_t,
  output logic              dqs_c,
  output logic              dqs_oe,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_col,
`ifdef WR_DBI_EN
  output logic [DQ_W/8-1:0] dbi_n,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(MAX_BL);
  localparam int CW = BW + 1;
  localparam int EW = DATA_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_POST  = 2'd3;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              work_bl_q, work_pre_q;
  logic [DATA_W-1:0] work_data_q;
  logic              err_ovf_q, err_unf_q, err_col_q;

  logic              can_start, pop, push_ok, in_burst;
  logic [CW-1:0]     last_pre, last_beat;
  logic [DQ_W-1:0]   beat;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Handshakes: a push is taken when wr_push is high and the queue has room (or is
  // popped in the same cycle); a start is taken when wr_rdy is high, the FSM is in
  // IDLE or POST and the queue holds a burst. Anything else is dropped and flagged.
  assign can_start = (state_q == S_IDLE) || (state_q == S_POST);
  assign pop       = wr_rdy && can_start && !fifo_empty;
  assign push_ok   = wr_push && (!fifo_full || pop);

  assign last_pre  = {{(CW-1){1'b0}}, work_pre_q};
  assign last_beat = work_bl_q ? CW'(MAX_BL/2 - 1) : CW'(MAX_BL - 1);

  always_ff @(posedge CK_t) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {bl_mode, wr_pre, wr_data};
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_bl_q   <= 1'b0;
      work_pre_q  <= 1'b0;
      work_data_q <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        {work_bl_q, work_pre_q, work_data_q} <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      err_ovf_q <= wr_push && fifo_full && !pop;
      err_unf_q <= wr_rdy && can_start && fifo_empty;
      err_col_q <= wr_rdy && !can_start;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        if (cnt_q == last_pre) begin
          state_d = S_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BURST: begin
        if (cnt_q == last_beat) begin
          state_d = S_POST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_POST: begin
        state_d = pop ? S_PRE : S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_burst    = (state_q == S_BURST);
  assign beat        = work_data_q[cnt_q[BW-1:0]*DQ_W +: DQ_W];
  assign dq_oe       = in_burst;
  assign dqs_oe      = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE);
  // DQS is high on even beats and idles high; PRE and POST hold it low.
  assign dqs_t       = (state_q == S_IDLE) || (in_burst && !cnt_q[0]);
  assign dqs_c       = in_burst ? cnt_q[0] : 1'b1;
  assign err_ovf     = err_ovf_q;
  assign err_unf     = err_unf_q;
  assign err_col     = err_col_q;
  assign dbg_state_o = state_q;

`ifdef WR_DBI_EN
  function automatic logic [3:0] ones8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, b[k]};
    return n;
  endfunction

  // A byte with more than four zeros (fewer than four ones) is sent inverted.
  always_comb begin
    dq    = '0;
    dbi_n = '1;
    if (in_burst) begin
      for (int b = 0; b < DQ_W/8; b++) begin
        if (ones8(beat[b*8 +: 8]) < 4'd4) begin
          dq[b*8 +: 8] = ~beat[b*8 +: 8];
          dbi_n[b]     = 1'b0;
        end else begin
          dq[b*8 +: 8] = beat[b*8 +: 8];
        end
      end
    end
  end
`else
  assign dq = in_burst ? beat : '0;
`endif

endmodule

// File: doc/ddr_wr_burst_engine.md
Name: ddr_wr_burst_engine

Overview:
Parametrised write-data path for the DDR controller. It queues write bursts announced at ACT/no-ACT time and, on each wr_rdy strobe, serialises one queued burst onto DQ with a matching differential DQS, including preamble and postamble. Burst length mode and preamble length are selectable per command. All logic is synchronous to a single clock; each clock cycle carries one data beat.

Parameters:
DQ_W, 8, DQ lane width in bits (multiple of 8)
MAX_BL, 8, beats in a full burst (BL8)
FIFO_DEPTH, 4, queued bursts (power of 2, ≥2)
DATA_W, MAX_BL*DQ_W, burst payload width (derived, not overridden)

Ports:
CK_t  in  1  clock
reset  in  1  asynchronous active-high reset
wr_push  in  1  enqueue burst (act_rdy | no_act_rdy)
bl_mode  in  1  0=BL8 (MAX_BL beats), 1=BC4 (MAX_BL/2 beats)
wr_pre  in  1  0=1-cycle preamble, 1=2-cycle preamble
wr_data  in  DATA_W  payload; beat 0 = bits [DQ_W-1:0]
wr_rdy  in  1  start strobe, one cycle
dq  out  DQ_W  write data
dq_oe  out  1  DQ drive enable
dqs_t  out  1  strobe true
dqs_c  out  1  strobe complement
dqs_oe  out  1  DQS drive enable
fifo_full  out  1  queue full
fifo_empty  out  1  queue empty
busy  out  1  state != IDLE
err_ovf  out  1  one-cycle pulse, push dropped
err_unf  out  1  one-cycle pulse, wr_rdy with empty queue
err_col  out  1  one-cycle pulse, wr_rdy dropped while busy

Behaviour:
- Reset (asynchronous): queue flushed (empty=1, full=0), state IDLE, dq=0, dq_oe=0, dqs_t=1, dqs_c=1, dqs_oe=0, all err_* 0. Reset asserted mid-burst aborts immediately and drops the remaining beats.
- Queue: circular buffer of {bl_mode, wr_pre, wr_data}. Pointers carry log2(FIFO_DEPTH)+1 bits; full/empty come from pointer compare and wrap naturally. A push while full and without a same-cycle pop is dropped and pulses err_ovf. A push and pop in the same cycle while full are both accepted.
- Start: wr_rdy is accepted only in IDLE or POST. If the queue is non-empty, the head is popped at that edge, latched into a working register, and the FSM moves to PRE on the next cycle. If the queue is empty, err_unf pulses and the state is unchanged. wr_rdy in PRE or BURST is dropped and pulses err_col.
- FSM:
  - IDLE: dqs_oe=0, dqs_t=dqs_c=1, dq_oe=0.
  - PRE: lasts 1 or 2 cycles per wr_pre. dqs_oe=1, dqs_t=0, dqs_c=1, dq_oe=0.
  - BURST: lasts N beats (N=MAX_BL, or MAX_BL/2 for BC4). dq_oe=1; dq carries beat i in cycle i. dqs_t=1 on beat 0 and toggles every cycle after; dqs_c=~dqs_t.
  - POST: 1 cycle. dqs_t=0, dqs_c=1, dqs_oe=1, dq_oe=0, dq=0. Next state is PRE if a start was accepted in this cycle, otherwise IDLE.
- Latency: wr_rdy at edge k gives the first PRE cycle at k+1 and the first data beat at k+1+pre_len.
- Beat counter width is log2(MAX_BL)+1 bits; it resets on entry to BURST.
- dq holds 0 whenever dq_oe=0.

Optional Feature:
WR_DBI_EN:
- When defined, adds output dbi_n (DQ_W/8 bits). Per byte per beat, if the byte contains more than 4 zeros it is driven inverted on dq with dbi_n=0; otherwise it is driven true with dbi_n=1.
- dbi_n=1 outside BURST and is 1 after reset.
- When undefined, the port is absent and dq carries the data unmodified.

Test Plan:
- Reset, push {BL8, pre=0, wr_data=64'h0807060504030201}, wr_rdy -> 1 PRE cycle, then dq 01..08 on 8 consecutive cycles, dqs_t 1,0,1,0,1,0,1,0, then one POST cycle, then IDLE with dqs_t=dqs_c=1.
- Push BC4 with pre=1 -> 2 PRE cycles, 4 beats, POST; busy high for exactly 7 cycles.
- 5 pushes with FIFO_DEPTH=4 and no wr_rdy -> fifo_full after the 4th push, err_ovf pulses once on the 5th; 4 drained bursts carry pushes 1-4 in order.
- wr_rdy with empty queue -> err_unf pulses, busy stays 0. wr_rdy during BURST -> err_col pulses, the in-flight burst is unaffected.
- Two queued bursts, second wr_rdy in POST -> POST followed directly by PRE; no IDLE cycle between bursts.
- Assert reset at beat 3 of a BL8 burst -> all outputs take reset values immediately and fifo_empty=1. With WR_DBI_EN and beat byte 8'h01: dq=8'hFE, dbi_n=0.
